// File: rtl/serial_pkg.sv
// Shared types and constants for the serial deserializer.
package serial_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RECV   = 2'd1,
      PARITY = 2'd2
   } state_t;

   localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/rx_shift_reg.sv
// Shift-in register: each enabled bit enters at the MSB, so the first bit ends in bit 0.
module rx_shift_reg
   import serial_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             Clk,
   input  logic             Reset,
   input  logic             En,
   input  logic             Clr,
   input  logic             Bit_In,
   output logic [WIDTH-1:0] Q
);

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset)
         Q <= '0;
      else if (Clr)
         Q <= '0;
      else if (En)
         Q <= {Bit_In, Q[WIDTH-1:1]};
   end

endmodule

// File: rtl/serial_deser_8.sv
// LSB-first serial-to-parallel receiver with a one-deep valid/ready output buffer.
// Define SERIAL_DESER_PARITY_EN to expect an even-parity bit after each data word.
module serial_deser_8
   import serial_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH,
   localparam int CW   = $clog2(WIDTH + 1)
) (
   input  logic             Clk,
   input  logic             Reset,
   input  logic             Bit_In,
   input  logic             Bit_Valid,
   input  logic             Clear,
   output logic [WIDTH-1:0] Data_Out,
   output logic             Data_Valid,
   input  logic             Data_Ready,
   output logic             Parity_Err,
   output logic             Overrun,
   output logic             Busy,
   output logic [CW-1:0]    Bit_Count
);

   state_t           state, state_nxt;
   logic [CW-1:0]    cnt_nxt;
   logic             shift_en;
   logic             done;
   logic [WIDTH-1:0] shreg;
   logic [WIDTH-1:0] word_nxt;

   rx_shift_reg #(.WIDTH(WIDTH)) u_shift (
      .Clk    (Clk),
      .Reset  (Reset),
      .En     (shift_en),
      .Clr    (Clear),
      .Bit_In (Bit_In),
      .Q      (shreg)
   );

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state     <= IDLE;
         Bit_Count <= '0;
      end else begin
         state     <= state_nxt;
         Bit_Count <= cnt_nxt;
      end
   end

   // word_nxt defaults to the register contents after the current bit shifts in
   always_comb begin
      state_nxt = state;
      cnt_nxt   = Bit_Count;
      shift_en  = 1'b0;
      done      = 1'b0;
      word_nxt  = {Bit_In, shreg[WIDTH-1:1]};
      if (Clear) begin
         state_nxt = IDLE;
         cnt_nxt   = '0;
      end else if (Bit_Valid) begin
         case (state)
            IDLE, RECV: begin
               shift_en = 1'b1;
               if (Bit_Count == CW'(WIDTH - 1)) begin
                  cnt_nxt = '0;
`ifdef SERIAL_DESER_PARITY_EN
                  state_nxt = PARITY;
`else
                  state_nxt = IDLE;
                  done      = 1'b1;
`endif
               end else begin
                  cnt_nxt   = Bit_Count + 1'b1;
                  state_nxt = RECV;
               end
            end
            PARITY: begin
               state_nxt = IDLE;
               done      = 1'b1;
               word_nxt  = shreg;
            end
            default: state_nxt = IDLE;
         endcase
      end
   end

   logic load_buf;
   assign load_buf = done && (!Data_Valid || Data_Ready);

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         Data_Out   <= '0;
         Data_Valid <= 1'b0;
         Overrun    <= 1'b0;
      end else begin
         if (Clear)
            Overrun <= 1'b0;
         if (load_buf) begin
            Data_Out   <= word_nxt;
            Data_Valid <= 1'b1;
         end else if (done) begin
            Overrun <= 1'b1;
         end else if (Data_Valid && Data_Ready) begin
            Data_Valid <= 1'b0;
         end
      end
   end

`ifdef SERIAL_DESER_PARITY_EN
   // Parity flag travels with the word it describes, so it only loads with the buffer
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset)
         Parity_Err <= 1'b0;
      else if (load_buf)
         Parity_Err <= ^{shreg, Bit_In};
   end
`else
   assign Parity_Err = 1'b0;
`endif

   assign Busy = (Bit_Count != '0) || (state == PARITY);

endmodule
